// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM output port with atomic SET/CLEAR and a self-timed pulse engine that inverts a bit mask.
// The pulse engine is built only when PIO_PULSE_EN is defined; otherwise address 1 is inert.
module avalon_pio_out_pulse #(
  parameter int              WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              PULSE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  // Handshake: a write is accepted on every clock edge where chipselect is high and
  // write_n is low; there is no wait state, and reads are combinational from address.
  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic             unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_next = data_reg;
    if (wr_en) begin
      case (address)
        2'd0:    data_next = wd;
        2'd2:    data_next = data_reg | wd;
        2'd3:    data_next = data_reg & ~wd;
        default: data_next = data_reg;
      endcase
    end
  end

`ifdef PIO_PULSE_EN
  typedef enum logic {IDLE, PULSE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pulse_mask;
  logic [CW-1:0]    cnt;
  logic             pulse_load;

  // A zero mask is not a request; a nonzero mask always (re)starts the pulse.
  assign pulse_load = wr_en && (address == 2'd1) && (wd != '0);

  // out_port is built from next-state values so it moves on the same edge as busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pulse_mask <= '0;
      cnt        <= '0;
      data_reg   <= RESET_VALUE;
      out_port   <= RESET_VALUE;
    end else begin
      data_reg <= data_next;
      if (pulse_load) begin
        state      <= PULSE;
        pulse_mask <= wd;
        cnt        <= CW'(PULSE_CYCLES);
        out_port   <= data_next ^ wd;
      end else if (state == PULSE && cnt == CW'(1)) begin
        state      <= IDLE;
        pulse_mask <= '0;
        cnt        <= '0;
        out_port   <= data_next;
      end else if (state == PULSE) begin
        cnt      <= cnt - CW'(1);
        out_port <= data_next ^ pulse_mask;
      end else begin
        out_port <= data_next;
      end
    end
  end

  assign busy = (state == PULSE);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[WIDTH-1:0] = data_reg;
      2'd1: begin
        readdata[WIDTH-1:0] = pulse_mask;
        readdata[31]        = busy;
      end
      2'd2: readdata[WIDTH-1:0] = out_port;
      2'd3: readdata[CW-1:0]    = cnt;
    endcase
  end
`else
  localparam int unused_cw = CW;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
      out_port <= RESET_VALUE;
    end else begin
      data_reg <= data_next;
      out_port <= data_next;
    end
  end

  assign busy = 1'b0;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[WIDTH-1:0] = data_reg;
      2'd2: readdata[WIDTH-1:0] = out_port;
      default: readdata = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_avalon_pio_out_pulse.sv
// Bench for avalon_pio_out_pulse: directed and random register traffic against an abstract model,
// checked per cycle by a scoreboard monitor. Follows PIO_PULSE_EN in the same way as the design.
module tb_avalon_pio_out_pulse;

  localparam int         W      = 8;
  localparam logic [7:0] RST_V  = 8'h01;
  localparam int         PC     = 4;
`ifdef PIO_PULSE_EN
  localparam bit         PULSE_EN = 1'b1;
`else
  localparam bit         PULSE_EN = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;
  logic          busy;

  avalon_pio_out_pulse #(
    .WIDTH(W), .RESET_VALUE(RST_V), .PULSE_CYCLES(PC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: resting value, pulse mask, and cycles of pulse still to run
  logic [7:0] m_data;
  logic [7:0] m_mask;
  int         m_left;

  int n_tests = 0;
  int n_fail  = 0;
  logic [40:0] exp_q[$];

  task automatic model_reset();
    m_data = RST_V;
    m_mask = 8'h00;
    m_left = 0;
  endtask

  function automatic logic [7:0] m_out();
    return (m_left > 0) ? (m_data ^ m_mask) : m_data;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      2'd0: r = {24'h0, m_data};
      2'd1: if (PULSE_EN) r = {(m_left > 0), 23'h0, m_mask};
      2'd2: r = {24'h0, m_out()};
      2'd3: if (PULSE_EN) r = 32'(m_left);
    endcase
    return r;
  endfunction

  // Applies the rules to the inputs the DUT sees at this edge.
  task automatic model_edge();
    logic [7:0] w;
    logic       req;
    w   = writedata[7:0];
    req = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else begin
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_data = w;
          2'd1: req = PULSE_EN && (w != 8'h00);
          2'd2: m_data = m_data | w;
          2'd3: m_data = m_data & ~w;
        endcase
      end
      if (req) begin
        m_mask = w;
        m_left = PC;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mask = 8'h00;
      end
    end
  endtask

  // driver: one call per clock; expectation is what the DUT shows during this cycle
  task automatic apply(input logic rn, input logic cs_i, input logic wn_i,
                       input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    model_edge();
    #1;
    reset_n    = rn;
    chipselect = cs_i;
    write_n    = wn_i;
    address    = a;
    writedata  = d;
    if (!rn) model_reset();
    exp_q.push_back({m_out(), (m_left > 0), exp_rd(a)});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    apply(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    apply(1'b1, 1'b1, 1'b1, a, 32'h0);
  endtask

  task automatic rst(input logic [1:0] a);
    apply(1'b0, 1'b0, 1'b1, a, 32'h0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [40:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (out_port !== e[40:33]) begin
        n_fail++;
        $display("FAIL out_port t=%0t addr=%0d got=%h exp=%h", $time, address, out_port, e[40:33]);
      end
      n_tests++;
      if (busy !== e[32]) begin
        n_fail++;
        $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, e[32]);
      end
      n_tests++;
      if (readdata !== e[31:0]) begin
        n_fail++;
        $display("FAIL readdata t=%0t addr=%0d got=%h exp=%h", $time, address, readdata, e[31:0]);
      end
    end
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'h0;
    model_reset();

    // reset values, DATA write, SET/CLEAR with junk upper bits
    rd(2'd0); rd(2'd2);
    wr(2'd0, 32'hFFFF_FF5A); rd(2'd0);
    wr(2'd2, 32'hABCD_EF81); rd(2'd2);
    wr(2'd3, 32'hFFFF_FF0F); rd(2'd0); rd(2'd2);

    // single pulse on resting 01
    wr(2'd0, 32'h0000_0001);
    wr(2'd1, 32'h0000_0001);
    repeat (6) rd(2'd1);
    rd(2'd3);

    // retrigger two cycles after first pulse, then a zero mask in IDLE
    wr(2'd1, 32'h0000_0003); rd(2'd1);
    wr(2'd1, 32'h0000_0002);
    repeat (6) rd(2'd1);
    wr(2'd1, 32'h0000_0000); rd(2'd1); rd(2'd2);

    // write arriving on the expiry cycle
    wr(2'd1, 32'h0000_0004); rd(2'd3); rd(2'd3); rd(2'd3);
    wr(2'd1, 32'h0000_0008);
    repeat (6) rd(2'd3);

    // resting-value updates during a pulse
    wr(2'd1, 32'h0000_0010); wr(2'd2, 32'h0000_0020); wr(2'd3, 32'h0000_0001);
    wr(2'd0, 32'h0000_0077);
    repeat (4) rd(2'd2);

    // async reset mid-pulse
    wr(2'd0, 32'h0000_00F0); wr(2'd1, 32'h0000_000F); rd(2'd1);
    rst(2'd0); rst(2'd2);
    rd(2'd3); rd(2'd2); rd(2'd1);

    // disabled-engine style request (all ones) plus random traffic
    wr(2'd1, 32'h0000_00FF); rd(2'd1); rd(2'd2);
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      if ($urandom_range(0, 40) == 0)
        rst(a);
      else
        apply(1'b1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, d);
    end
    rd(2'd0);

    @(posedge clk);
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
